// File: rtl/keypad_scan_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_encoder_if
// Description : Bundle of key-matrix pins and the key-code valid/ready
//               handshake between the keypad scanner and the calculator core.
//               The scanner uses the master modport and the core (or a test
//               environment) uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scan_encoder_if;
   logic [3:0] JM1222HM_cols;   // matrix columns, active-low, asynchronous
   logic [3:0] JM1222HM_rows;   // matrix row drive, one-hot-low
   logic [3:0] JM1222HM_code;   // key code {row, col}
   logic       JM1222HM_valid;  // code holds an unconsumed key
   logic       JM1222HM_ready;  // consumer accepts the code
   logic       JM1222HM_ovf;    // a press was dropped while valid was pending

   modport master (
      input  JM1222HM_cols,
      input  JM1222HM_ready,
      output JM1222HM_rows,
      output JM1222HM_code,
      output JM1222HM_valid,
      output JM1222HM_ovf
   );

   modport slave (
      output JM1222HM_cols,
      output JM1222HM_ready,
      input  JM1222HM_rows,
      input  JM1222HM_code,
      input  JM1222HM_valid,
      input  JM1222HM_ovf
   );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_encoder
// Description : Scans a 4x4 active-low key matrix one row at a time,
//               debounces a single pressed key, and hands a 4-bit code
//               {row, col} to the calculator core on a valid/ready handshake.
//               A press that arrives while a code is still pending is dropped
//               and flagged with a one-cycle ovf pulse.
//               Optional macro KEYPAD_REPEAT_EN: while a key stays held, the
//               same code is re-emitted every REPEAT_DLY samples.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_encoder #(
   parameter int SCAN_DIV     = 1000,  // cycles per row, >= 4
   parameter int DEBOUNCE_CNT = 8      // agreeing samples for press/release, >= 1
`ifdef KEYPAD_REPEAT_EN
   ,parameter int REPEAT_DLY  = 64     // samples between auto-repeat codes
`endif
) (
   input  wire logic             JM1222HM_clk,
   input  wire logic             JM1222HM_rst,
   keypad_scan_encoder_if.master kp
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);
`ifdef KEYPAD_REPEAT_EN
   localparam int RP_W  = $clog2(REPEAT_DLY + 1);
`endif

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   state_t            state_q;
   logic [3:0]        sync1_q;
   logic [3:0]        sync2_q;
   logic [DIV_W-1:0]  div_q;
   logic [3:0]        rows_q;
   logic [DB_W-1:0]   stable_q;
   logic [DB_W-1:0]   rel_q;
   logic [3:0]        cand_q;
   logic [3:0]        code_q;
   logic              valid_q;
   logic              ovf_q;
`ifdef KEYPAD_REPEAT_EN
   logic [RP_W-1:0]   rep_q;
`endif

   logic              w_sample;
   logic              w_single;
   logic [1:0]        w_col;
   logic [1:0]        w_row;
   logic              w_same;
   logic              w_all_high;
   logic              w_emit;
   logic [3:0]        w_new_code;

   assign w_sample   = (div_q == DIV_W'(SCAN_DIV - 1));
   assign w_all_high = (sync2_q == 4'b1111);
   assign w_same     = w_single && (w_col == cand_q[1:0]);

   // Decode the synchronized columns (exactly one low bit is a key) and the
   // currently driven row index.
   always_comb begin
      w_single = 1'b1;
      w_col    = 2'd0;
      case (sync2_q)
         4'b1110: w_col = 2'd0;
         4'b1101: w_col = 2'd1;
         4'b1011: w_col = 2'd2;
         4'b0111: w_col = 2'd3;
         default: w_single = 1'b0;
      endcase
      case (rows_q)
         4'b1101: w_row = 2'd1;
         4'b1011: w_row = 2'd2;
         4'b0111: w_row = 2'd3;
         default: w_row = 2'd0;
      endcase
   end

   // Decide whether this sample produces a key code and which code it is.
   always_comb begin
      w_emit     = 1'b0;
      w_new_code = cand_q;
      if (w_sample) begin
         case (state_q)
            ST_SCAN: begin
               w_emit     = w_single && (DEBOUNCE_CNT == 1);
               w_new_code = {w_row, w_col};
            end
            ST_DEBOUNCE: w_emit = w_same && (stable_q == DB_W'(DEBOUNCE_CNT - 1));
`ifdef KEYPAD_REPEAT_EN
            ST_HELD:     w_emit = w_same && (rep_q == RP_W'(REPEAT_DLY - 1));
`endif
            default:     w_emit = 1'b0;
         endcase
      end
   end

   // Scan/debounce state machine with registered row drive and handshake outputs.
   always_ff @(posedge JM1222HM_clk) begin
      if (JM1222HM_rst) begin
         state_q  <= ST_SCAN;
         sync1_q  <= 4'b1111;
         sync2_q  <= 4'b1111;
         div_q    <= '0;
         rows_q   <= 4'b1110;
         stable_q <= '0;
         rel_q    <= '0;
         cand_q   <= 4'd0;
         code_q   <= 4'd0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_q    <= '0;
`endif
      end else begin
         sync1_q <= kp.JM1222HM_cols;
         sync2_q <= sync1_q;
         div_q   <= w_sample ? '0 : div_q + DIV_W'(1);

         // Handshake: consume first, a same-cycle emit may reload.
         ovf_q <= 1'b0;
         if (valid_q && kp.JM1222HM_ready) begin
            valid_q <= 1'b0;
         end
         if (w_emit) begin
            if (!valid_q || kp.JM1222HM_ready) begin
               code_q  <= w_new_code;
               valid_q <= 1'b1;
            end else begin
               ovf_q   <= 1'b1;
            end
         end

         if (w_sample) begin
            case (state_q)
               ST_SCAN: begin
                  if (w_single) begin
                     cand_q <= {w_row, w_col};
                     if (DEBOUNCE_CNT == 1) begin
                        state_q <= ST_HELD;
                        rel_q   <= '0;
                     end else begin
                        state_q  <= ST_DEBOUNCE;
                        stable_q <= DB_W'(1);
                     end
`ifdef KEYPAD_REPEAT_EN
                     rep_q <= '0;
`endif
                  end else begin
                     rows_q <= {rows_q[2:0], rows_q[3]};
                  end
               end
               ST_DEBOUNCE: begin
                  if (w_same) begin
                     if (stable_q == DB_W'(DEBOUNCE_CNT - 1)) begin
                        state_q  <= ST_HELD;
                        stable_q <= '0;
                        rel_q    <= '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_q    <= '0;
`endif
                     end else begin
                        stable_q <= stable_q + DB_W'(1);
                     end
                  end else begin
                     state_q  <= ST_SCAN;
                     stable_q <= '0;
                     rows_q   <= {rows_q[2:0], rows_q[3]};
                  end
               end
               ST_HELD: begin
                  if (w_all_high) begin
                     if (rel_q == DB_W'(DEBOUNCE_CNT - 1)) begin
                        state_q <= ST_SCAN;
                        rel_q   <= '0;
                        rows_q  <= {rows_q[2:0], rows_q[3]};
                     end else begin
                        rel_q <= rel_q + DB_W'(1);
                     end
                  end else begin
                     rel_q <= '0;
                  end
`ifdef KEYPAD_REPEAT_EN
                  // Only an unchanged single-key pattern keeps the repeat count.
                  if (w_same) begin
                     rep_q <= (rep_q == RP_W'(REPEAT_DLY - 1)) ? '0 : rep_q + RP_W'(1);
                  end else begin
                     rep_q <= '0;
                  end
`endif
               end
               default: state_q <= ST_SCAN;
            endcase
         end
      end
   end

   assign kp.JM1222HM_rows  = rows_q;
   assign kp.JM1222HM_code  = code_q;
   assign kp.JM1222HM_valid = valid_q;
   assign kp.JM1222HM_ovf   = ovf_q;

endmodule
`default_nettype wire
